gene_attractor_classifier: RTL and testbench

//  Consumes initial values for the N-bit gene network and classifies each trajectory.

---
 rtl/gene_attractor_classifier_if.sv | 22 ++
 rtl/gene_attractor_classifier.sv | 104 ++++++++++
 tb/tb_gene_attractor_classifier.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gene_attractor_classifier_if.sv
// gene_attractor_classifier_if: request/result handshake plus the gene_net successor port.
interface gene_attractor_classifier_if #(parameter int N = 8);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] init_val;
   logic [N-1:0] net_state;
   logic [N-1:0] net_next;
   logic         out_valid;
   logic         out_ready;
   logic         res_fixed;
   logic [N:0]   res_cycle_len;
   logic [N-1:0] res_min_state;
   logic         res_timeout;
   modport master (
      output in_valid, init_val, net_next, out_ready,
      input  in_ready, net_state, out_valid, res_fixed, res_cycle_len, res_min_state, res_timeout
   );
   modport slave (
      input  in_valid, init_val, net_next, out_ready,
      output in_ready, net_state, out_valid, res_fixed, res_cycle_len, res_min_state, res_timeout
   );
endinterface

// File: rtl/gene_attractor_classifier.sv
// gene_attractor_classifier: Brent cycle detection over an external gene_net, then one walk
// around the cycle to find its length and minimum state (the canonical attractor ID).
module gene_attractor_classifier #(
   parameter int N         = 8,
   parameter int MAX_STEPS = 1024
) (
   input logic clk,
   input logic rst,
   gene_attractor_classifier_if.slave io_bus
);
   localparam int SW = $clog2(MAX_STEPS) + 1;
   localparam logic [N+1:0] L1 = (N+2)'(1);
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEARCH, S_WALK, S_DONE} state_t;
   state_t         r_state;
   logic [N-1:0]   r_tort, r_hare, r_min, r_res_min;
   logic [N+1:0]   r_lam, r_power, r_cnt;
   logic [SW-1:0]  r_steps;
   logic [N:0]     r_res_len;
   logic           r_res_fixed, r_res_to, r_out_valid;
   logic [N-1:0]   w_next, w_walk_min, w_fin_min;
   logic           w_match, w_to, w_busy, w_fin;
   assign w_next     = io_bus.net_next;
   assign w_walk_min = (w_next < r_min) ? w_next : r_min;
   assign w_match    = r_tort == r_hare;
   assign w_to       = r_steps == SW'(MAX_STEPS - 1);
   assign w_busy     = r_state == S_LOAD || r_state == S_SEARCH || r_state == S_WALK;
   // Finishing on the same edge as the step budget runs out still counts as a completion.
   assign w_fin      = (r_state == S_SEARCH && w_match && r_lam == L1) || (r_state == S_WALK && r_cnt == L1);
   assign w_fin_min  = (r_state == S_SEARCH) ? r_hare : w_walk_min;
   assign io_bus.in_ready      = r_state == S_IDLE && !rst;
   assign io_bus.net_state     = r_hare;
   assign io_bus.out_valid     = r_out_valid;
   assign io_bus.res_fixed     = r_res_fixed;
   assign io_bus.res_cycle_len = r_res_len;
   assign io_bus.res_min_state = r_res_min;
   assign io_bus.res_timeout   = r_res_to;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_tort      <= '0;
         r_hare      <= '0;
         r_min       <= '0;
         r_lam       <= '0;
         r_power     <= '0;
         r_cnt       <= '0;
         r_steps     <= '0;
         r_out_valid <= 1'b0;
         r_res_fixed <= 1'b0;
         r_res_len   <= '0;
         r_res_min   <= '0;
         r_res_to    <= 1'b0;
      end else if (w_fin || (w_busy && w_to)) begin
         r_state     <= S_DONE;
         r_out_valid <= 1'b1;
         r_res_to    <= !w_fin;
         r_res_fixed <= w_fin && r_lam == L1;
         r_res_len   <= w_fin ? r_lam[N:0] : '0;
         r_res_min   <= w_fin ? w_fin_min : '0;
      end else begin
         case (r_state)
            S_IDLE: if (io_bus.in_valid) begin
               r_tort  <= io_bus.init_val;
               r_hare  <= io_bus.init_val;
               r_steps <= '0;
               r_state <= S_LOAD;
            end
            S_LOAD: begin
               r_hare  <= w_next;
               r_lam   <= L1;
               r_power <= L1;
               r_steps <= r_steps + SW'(1);
               r_state <= S_SEARCH;
            end
            S_SEARCH: begin
               r_steps <= r_steps + SW'(1);
               if (w_match) begin
                  r_min   <= r_hare;
                  r_cnt   <= r_lam - L1;
                  r_state <= S_WALK;
               end else if (r_power == r_lam) begin
                  r_tort  <= r_hare;
                  r_power <= r_power << 1;
                  r_lam   <= L1;
                  r_hare  <= w_next;
               end else begin
                  r_lam  <= r_lam + L1;
                  r_hare <= w_next;
               end
            end
            S_WALK: begin
               r_hare  <= w_next;
               r_min   <= w_walk_min;
               r_cnt   <= r_cnt - L1;
               r_steps <= r_steps + SW'(1);
            end
            S_DONE: if (io_bus.out_ready) begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gene_attractor_classifier.sv
// tb_gene_attractor_classifier: directed scenarios with stub gene_net successor functions.
module tb_gene_attractor_classifier;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   mode = 0;
   int   nchk = 0;
   int   nerr = 0;
   int   lat;
   gene_attractor_classifier_if #(.N(8)) b ();
   gene_attractor_classifier_if #(.N(8)) c ();
   gene_attractor_classifier #(.N(8), .MAX_STEPS(1024)) dut   (.clk(clk), .rst(rst), .io_bus(b));
   gene_attractor_classifier #(.N(8), .MAX_STEPS(64))   dut64 (.clk(clk), .rst(rst), .io_bus(c));
   always #5 clk = ~clk;
   // 0: identity, 1: shift right, 2: rotate left, 3: increment mod 256
   function automatic logic [7:0] f(input int m, input logic [7:0] x);
      return m == 0 ? x : m == 1 ? x >> 1 : m == 2 ? {x[6:0], x[7]} : x + 8'd1;
   endfunction
   assign b.net_next = f(mode, b.net_state);
   assign c.net_next = f(mode, c.net_state);
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic classify(input logic [7:0] v, output int n);
      for (int i = 0; i < 20 && !b.in_ready; i++) tick();
      b.in_valid = 1'b1;
      b.init_val = v;
      tick();
      b.in_valid = 1'b0;
      n = 1;
      while (!b.out_valid && n < 3000) begin
         tick();
         n++;
      end
   endtask
   task automatic consume();
      b.out_ready = 1'b1;
      tick();
      b.out_ready = 1'b0;
   endtask
   task automatic test_reset();
      tick();
      tick();
      nchk++; if (b.in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready: got %b want 0", b.in_ready); end
      nchk++; if (b.out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b want 0", b.out_valid); end
      nchk++; if (b.res_cycle_len !== 9'd0 || b.res_min_state !== 8'd0) begin nerr++; $display("FAIL rst_res: len=%0d min=%h want 0/00", b.res_cycle_len, b.res_min_state); end
      nchk++; if (b.net_state !== 8'd0) begin nerr++; $display("FAIL rst_net_state: got %h want 00", b.net_state); end
      rst = 1'b0;
      #1;
      nchk++; if (b.in_ready !== 1'b1) begin nerr++; $display("FAIL idle_in_ready: got %b want 1", b.in_ready); end
   endtask
   task automatic test_fixed_point();
      mode = 0;
      classify(8'h63, lat);
      nchk++; if (lat !== 3) begin nerr++; $display("FAIL fix63_latency: got %0d want 3", lat); end
      nchk++; if (b.res_fixed !== 1'b1 || b.res_timeout !== 1'b0) begin nerr++; $display("FAIL fix63_flags: fixed=%b to=%b want 1/0", b.res_fixed, b.res_timeout); end
      nchk++; if (b.res_cycle_len !== 9'd1 || b.res_min_state !== 8'h63) begin nerr++; $display("FAIL fix63_res: len=%0d min=%h want 1/63", b.res_cycle_len, b.res_min_state); end
      consume();
      nchk++; if (b.out_valid !== 1'b0 || b.in_ready !== 1'b1) begin nerr++; $display("FAIL fix63_consume: ov=%b ir=%b want 0/1", b.out_valid, b.in_ready); end
      mode = 1;
      classify(8'hFF, lat);
      nchk++; if (b.res_fixed !== 1'b1 || b.res_cycle_len !== 9'd1 || b.res_min_state !== 8'h00) begin nerr++; $display("FAIL shr_ff: fixed=%b len=%0d min=%h want 1/1/00", b.res_fixed, b.res_cycle_len, b.res_min_state); end
      consume();
   endtask
   task automatic test_rotate();
      mode = 2;
      classify(8'h38, lat);
      nchk++; if (b.res_fixed !== 1'b0 || b.res_timeout !== 1'b0) begin nerr++; $display("FAIL rot38_flags: fixed=%b to=%b want 0/0", b.res_fixed, b.res_timeout); end
      nchk++; if (b.res_cycle_len !== 9'd8 || b.res_min_state !== 8'h07) begin nerr++; $display("FAIL rot38_res: len=%0d min=%h want 8/07", b.res_cycle_len, b.res_min_state); end
      consume();
      classify(8'h55, lat);
      nchk++; if (b.res_cycle_len !== 9'd2 || b.res_min_state !== 8'h55 || b.res_fixed !== 1'b0) begin nerr++; $display("FAIL rot55_res: len=%0d min=%h fixed=%b want 2/55/0", b.res_cycle_len, b.res_min_state, b.res_fixed); end
      consume();
   endtask
   task automatic test_full_cycle();
      mode = 3;
      classify(8'h00, lat);
      nchk++; if (b.res_cycle_len !== 9'd256 || b.res_min_state !== 8'h00) begin nerr++; $display("FAIL inc_res: len=%0d min=%h want 256/00", b.res_cycle_len, b.res_min_state); end
      nchk++; if (b.res_timeout !== 1'b0 || b.res_fixed !== 1'b0) begin nerr++; $display("FAIL inc_flags: to=%b fixed=%b want 0/0", b.res_timeout, b.res_fixed); end
      consume();
   endtask
   task automatic test_timeout();
      int n;
      mode = 3;
      c.in_valid = 1'b1;
      c.init_val = 8'h00;
      tick();
      c.in_valid = 1'b0;
      n = 1;
      while (!c.out_valid && n < 3000) begin
         tick();
         n++;
      end
      nchk++; if (n !== 65) begin nerr++; $display("FAIL to_latency: got %0d want 65", n); end
      nchk++; if (c.res_timeout !== 1'b1 || c.res_fixed !== 1'b0) begin nerr++; $display("FAIL to_flags: to=%b fixed=%b want 1/0", c.res_timeout, c.res_fixed); end
      nchk++; if (c.res_cycle_len !== 9'd0 || c.res_min_state !== 8'h00) begin nerr++; $display("FAIL to_res: len=%0d min=%h want 0/00", c.res_cycle_len, c.res_min_state); end
      c.out_ready = 1'b1;
      tick();
      c.out_ready = 1'b0;
      nchk++; if (c.out_valid !== 1'b0) begin nerr++; $display("FAIL to_consume: ov=%b want 0", c.out_valid); end
   endtask
   task automatic test_backpressure();
      int bad = 0;
      mode = 2;
      classify(8'h38, lat);
      for (int i = 0; i < 10; i++) begin
         b.in_valid = i[0];
         b.init_val = 8'h63;
         tick();
         if (b.out_valid !== 1'b1 || b.in_ready !== 1'b0 || b.res_cycle_len !== 9'd8 || b.res_min_state !== 8'h07) bad++;
      end
      b.in_valid = 1'b0;
      nchk++; if (bad !== 0) begin nerr++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); end
      consume();
      nchk++; if (b.out_valid !== 1'b0 || b.in_ready !== 1'b1) begin nerr++; $display("FAIL bp_consume: ov=%b ir=%b want 0/1", b.out_valid, b.in_ready); end
      tick();
      tick();
      nchk++; if (b.out_valid !== 1'b0 || b.res_cycle_len !== 9'd8 || b.res_min_state !== 8'h07) begin nerr++; $display("FAIL bp_once: ov=%b len=%0d min=%h want 0/8/07", b.out_valid, b.res_cycle_len, b.res_min_state); end
   endtask
   task automatic test_reset_mid();
      mode = 3;
      b.in_valid = 1'b1;
      b.init_val = 8'h00;
      tick();
      b.in_valid = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      nchk++; if (b.out_valid !== 1'b0 || b.in_ready !== 1'b1) begin nerr++; $display("FAIL rstmid_idle: ov=%b ir=%b want 0/1", b.out_valid, b.in_ready); end
      mode = 2;
      classify(8'h38, lat);
      nchk++; if (b.res_cycle_len !== 9'd8 || b.res_min_state !== 8'h07) begin nerr++; $display("FAIL rstmid_rot38: len=%0d min=%h want 8/07", b.res_cycle_len, b.res_min_state); end
      consume();
   endtask
   initial begin
      b.in_valid = 1'b0; b.init_val = '0; b.out_ready = 1'b0;
      c.in_valid = 1'b0; c.init_val = '0; c.out_ready = 1'b0;
      test_reset();
      test_fixed_point();
      test_rotate();
      test_full_cycle();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
